dmem_arbiter: RTL and testbench

//  Two-requester arbiter in front of the single-port data memory (1 write port, combinational read).

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_resp_reg.sv | 38 +++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Which requester owned the most recent grant
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Byte address bits below this index select a byte within a word
    localparam int WORD_LSB       = 2;
    // Default backing-memory depth and its index width
    localparam int DEPTH_WORDS_DEF = 64;
    localparam int IDX_W           = $clog2(DEPTH_WORDS_DEF);

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_resp_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_resp_reg
//  Description : One-cycle registered response (rvalid/rdata/err) for a
//                single arbiter port.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arb_resp_reg
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt,
    input  logic              rd_ok,
    input  logic              in_range,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    // Capture the grant-cycle outcome; writes and bad addresses return zero data
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= gnt;
            rdata  <= (gnt && rd_ok) ? mem_rd : '0;
            err    <= gnt && !in_range;
        end
    end

endmodule : dmem_arb_resp_reg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing a single-port data memory
//                between the CPU load/store port and the loader/DMA port.
//                One access per cycle, registered one-cycle response.
//                Optional macro DMEM_ARB_LOCK_EN adds cpu_lock/dma_lock and
//                a bounded lock counter (LOCK_MAX consecutive grants).
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64
`ifdef DMEM_ARB_LOCK_EN
   ,parameter int LOCK_MAX    = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              cpu_lock,
`endif
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              dma_lock,
`endif
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int                         c_WIDX_W = ADDR_W - WORD_LSB;
    localparam logic [c_WIDX_W-1:0]        c_DEPTH  = c_WIDX_W'(DEPTH_WORDS);

    owner_e r_last_owner;
    owner_e w_last_owner_nxt;
    logic   w_cpu_gnt;
    logic   w_dma_gnt;
    logic   w_cpu_in_range;
    logic   w_dma_in_range;
    logic   w_hold_cpu;
    logic   w_hold_dma;

    // Word index range check; the byte offset bits play no part
    assign w_cpu_in_range = (cpu_addr[ADDR_W-1:WORD_LSB] < c_DEPTH);
    assign w_dma_in_range = (dma_addr[ADDR_W-1:WORD_LSB] < c_DEPTH);

`ifdef DMEM_ARB_LOCK_EN
    localparam int                  c_CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [c_CNT_W-1:0]  c_LOCK_MAX = c_CNT_W'(LOCK_MAX);

    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_lock_cnt_nxt;
    logic               w_gnt_lock;
    logic               w_same_owner;

    // A lock only holds once the owner already has a locked grant in flight
    // and the budget is not exhausted
    always_comb begin
        w_hold_cpu = (r_last_owner == OWN_CPU) && cpu_req && cpu_lock &&
                     (r_lock_cnt != '0) && (r_lock_cnt < c_LOCK_MAX);
        w_hold_dma = (r_last_owner == OWN_DMA) && dma_req && dma_lock &&
                     (r_lock_cnt != '0) && (r_lock_cnt < c_LOCK_MAX);
    end

    // Count consecutive locked grants to one owner, saturating at LOCK_MAX
    always_comb begin
        w_gnt_lock     = (w_cpu_gnt && cpu_lock) || (w_dma_gnt && dma_lock);
        w_same_owner   = (w_cpu_gnt && (r_last_owner == OWN_CPU)) ||
                         (w_dma_gnt && (r_last_owner == OWN_DMA));
        w_lock_cnt_nxt = '0;
        if (w_gnt_lock) begin
            if (w_same_owner && (r_lock_cnt != '0)) begin
                w_lock_cnt_nxt = (r_lock_cnt == c_LOCK_MAX) ? r_lock_cnt
                                                            : r_lock_cnt + 1'b1;
            end else begin
                w_lock_cnt_nxt = c_CNT_W'(1);
            end
        end
    end

    // Lock counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else begin
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end
`else
    assign w_hold_cpu = 1'b0;
    assign w_hold_dma = 1'b0;
`endif

    // Owner state register; DMA at reset so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= OWN_DMA;
        end else begin
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Grant decision (lock hold, then round-robin) and next owner
    always_comb begin
        w_cpu_gnt        = 1'b0;
        w_dma_gnt        = 1'b0;
        if (!reset) begin
            if (w_hold_cpu) begin
                w_cpu_gnt = 1'b1;
            end else if (w_hold_dma) begin
                w_dma_gnt = 1'b1;
            end else if (cpu_req && dma_req) begin
                w_cpu_gnt = (r_last_owner == OWN_DMA);
                w_dma_gnt = (r_last_owner == OWN_CPU);
            end else begin
                w_cpu_gnt = cpu_req;
                w_dma_gnt = dma_req;
            end
        end
        w_last_owner_nxt = r_last_owner;
        if (w_cpu_gnt) begin
            w_last_owner_nxt = OWN_CPU;
        end else if (w_dma_gnt) begin
            w_last_owner_nxt = OWN_DMA;
        end
    end

    // Memory-side mux; out-of-range writes are suppressed here
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (w_cpu_gnt) begin
            mem_we = cpu_we && w_cpu_in_range;
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
        end else if (w_dma_gnt) begin
            mem_we = dma_we && w_dma_in_range;
            mem_a  = dma_addr;
            mem_wd = dma_wdata;
        end
    end

    assign cpu_gnt = w_cpu_gnt;
    assign dma_gnt = w_dma_gnt;

    dmem_arb_resp_reg #(
        .DATA_W (DATA_W)
    ) u_cpu_resp (
        .clk      (clk),
        .reset    (reset),
        .gnt      (w_cpu_gnt),
        .rd_ok    (!cpu_we && w_cpu_in_range),
        .in_range (w_cpu_in_range),
        .mem_rd   (mem_rd),
        .rvalid   (cpu_rvalid),
        .rdata    (cpu_rdata),
        .err      (cpu_err)
    );

    dmem_arb_resp_reg #(
        .DATA_W (DATA_W)
    ) u_dma_resp (
        .clk      (clk),
        .reset    (reset),
        .gnt      (w_dma_gnt),
        .rd_ok    (!dma_we && w_dma_in_range),
        .in_range (w_dma_in_range),
        .mem_rd   (mem_rd),
        .rvalid   (dma_rvalid),
        .rdata    (dma_rdata),
        .err      (dma_err)
    );

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a simple
//                64-word memory model (word i preloaded with 0x1000_0000 | i).
//                Lock scenario is compiled in with DMEM_ARB_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_LOCK_EN
    logic        cpu_lock, dma_lock;
`endif

    logic        init;
    logic [31:0] mem [0:DEPTH_WORDS_DEF-1];
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_WORDS (64)
`ifdef DMEM_ARB_LOCK_EN
       ,.LOCK_MAX    (4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .cpu_lock   (cpu_lock),
`endif
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .dma_lock   (dma_lock),
`endif
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_err    (dma_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Memory model: combinational read, posedge write; index wraps on the
    // low address bits so a leaked out-of-range write would corrupt word 0
    assign mem_rd = mem[mem_a[IDX_W+1:2]];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < DEPTH_WORDS_DEF; i++) mem[i] <= 32'h1000_0000 | i;
        end else if (mem_we) begin
            mem[mem_a[IDX_W+1:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef DMEM_ARB_LOCK_EN
    logic [5:0] lock_exp;
`endif

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_wdata = 32'hFFFF_FFFF;
`ifdef DMEM_ARB_LOCK_EN
        cpu_lock = 1'b0; dma_lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1; init = 1'b0; #3;
        // Reset state, requests held high to exercise gating
        check("rst_cpu_gnt",    cpu_gnt,    0);
        check("rst_dma_gnt",    dma_gnt,    0);
        check("rst_mem_we",     mem_we,     0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_cpu_rdata",  cpu_rdata,  0);

        // 1: lone CPU read of 0x10
        step(); reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; #3;
        check("t1_cpu_gnt", cpu_gnt, 1);
        check("t1_dma_gnt", dma_gnt, 0);
        check("t1_mem_we",  mem_we,  0);
        check("t1_mem_a",   mem_a,   32'h10);
        step(); cpu_req = 1'b0; #3;
        check("t1_cpu_rvalid", cpu_rvalid, 1);
        check("t1_cpu_rdata",  cpu_rdata,  32'h1000_0004);
        check("t1_cpu_err",    cpu_err,    0);
        check("t1_dma_rvalid", dma_rvalid, 0);

        // 2: simultaneous reads after reset alternate CPU, DMA, CPU, DMA
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4; #3;
        check("t2_c0_cpu_gnt", cpu_gnt, 1);
        check("t2_c0_dma_gnt", dma_gnt, 0);
        step(); #3;
        check("t2_c1_dma_gnt",    dma_gnt,    1);
        check("t2_c1_cpu_gnt",    cpu_gnt,    0);
        check("t2_c1_cpu_rvalid", cpu_rvalid, 1);
        check("t2_c1_cpu_rdata",  cpu_rdata,  32'h1000_0000);
        step(); #3;
        check("t2_c2_cpu_gnt",    cpu_gnt,    1);
        check("t2_c2_dma_rvalid", dma_rvalid, 1);
        check("t2_c2_dma_rdata",  dma_rdata,  32'h1000_0001);
        check("t2_c2_cpu_rvalid", cpu_rvalid, 0);
        step(); #3;
        check("t2_c3_dma_gnt", dma_gnt, 1);
        step(); cpu_req = 1'b0; dma_req = 1'b0; #3;
        check("t2_idle_cpu_gnt", cpu_gnt, 0);

        // 3: DMA writes 0xCAFEF00D at 0x20, CPU reads it back
        step(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D; #3;
        check("t3_dma_gnt", dma_gnt, 1);
        check("t3_mem_we",  mem_we,  1);
        check("t3_mem_wd",  mem_wd,  32'hCAFE_F00D);
        step(); dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; #3;
        check("t3_cpu_gnt",    cpu_gnt,    1);
        check("t3_dma_rvalid", dma_rvalid, 1);
        check("t3_dma_rdata",  dma_rdata,  0);
        step(); cpu_req = 1'b0; #3;
        check("t3_cpu_rvalid", cpu_rvalid, 1);
        check("t3_cpu_rdata",  cpu_rdata,  32'hCAFE_F00D);

        // 4: out-of-range CPU write to word 64, then back-to-back read of word 0
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1234_5678; #3;
        check("t4_cpu_gnt", cpu_gnt, 1);
        check("t4_mem_we",  mem_we,  0);
        step(); cpu_we = 1'b0; cpu_addr = 32'h0; #3;
        check("t4_cpu_rvalid", cpu_rvalid, 1);
        check("t4_cpu_err",    cpu_err,    1);
        check("t4_cpu_rdata",  cpu_rdata,  0);
        check("t4_b2b_gnt",    cpu_gnt,    1);
        step(); cpu_req = 1'b0; #3;
        check("t4_rd_rvalid", cpu_rvalid, 1);
        check("t4_rd_err",    cpu_err,    0);
        check("t4_rd_word0",  cpu_rdata,  32'h1000_0000);

        // 5: reset in the cycle after a grant drops the response
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; #3;
        check("t5_cpu_gnt", cpu_gnt, 1);
        step(); reset = 1'b1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_wdata = 32'hFFFF_FFFF; #3;
        check("t5_rst_mem_we",  mem_we,  0);
        check("t5_rst_cpu_gnt", cpu_gnt, 0);
        check("t5_rst_dma_gnt", dma_gnt, 0);
        step(); reset = 1'b0; dma_we = 1'b0; dma_addr = 32'h4; #3;
        check("t5_cpu_rvalid", cpu_rvalid, 0);
        check("t5_dma_rvalid", dma_rvalid, 0);
        check("t5_first_cpu",  cpu_gnt,    1);
        check("t5_first_dma",  dma_gnt,    0);
        step(); #3;
        check("t5_dma_gnt",   dma_gnt,   1);
        check("t5_cpu_rdata", cpu_rdata, 32'h1000_0002);
        step(); cpu_req = 1'b0; dma_req = 1'b0; #3;
        check("t5_dma_rdata", dma_rdata, 32'h1000_0001);

`ifdef DMEM_ARB_LOCK_EN
        // 6: DMA locks while both request: C, D, D, D, D, C
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4; dma_lock = 1'b1;
        lock_exp = 6'b011110;
        for (int i = 0; i < 6; i++) begin
            #3;
            check($sformatf("t6_c%0d_dma_gnt", i), dma_gnt, lock_exp[i]);
            check($sformatf("t6_c%0d_cpu_gnt", i), cpu_gnt, !lock_exp[i]);
            step();
        end
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
